ipg_axis_pkt_gen: RTL and testbench

Synthesizable AXI-Stream packet generator that drives the `tx_axis_*` input of `ipg_mac_phy_10g`, directly upstream of the MAC TX path. It emits a run of packets with a configured byte length and a configured idle gap in cycles between packets. Payload is deterministic: each beat carries a packet sequence number and a beat index, so a downstream RX checker can verify order and content. It replaces hand-timed stimulus in loopback IPG experiments.

---
 rtl/ipg_axis_pkt_gen.sv | 218 +++++++++++++++++++++
 tb/tb_ipg_axis_pkt_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ipg_axis_pkt_gen.sv
// AXI-Stream packet generator feeding the MAC TX path: runs of fixed-length packets separated by idle gaps.
// Optional tuser error injection (err_inject port) is built when IPG_PKT_GEN_ERR_INJ_EN is defined.
module ipg_axis_pkt_gen #(
  parameter int LEN_WIDTH = 16,
  parameter int GAP_WIDTH = 8
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] cfg_pkt_len,
  input  logic [31:0]          cfg_pkt_count,
  input  logic [GAP_WIDTH-1:0] cfg_gap_cycles,
`ifdef IPG_PKT_GEN_ERR_INJ_EN
  input  logic                 err_inject,
`endif
  output logic [63:0]          m_axis_tdata,
  output logic [7:0]           m_axis_tkeep,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [31:0]          pkt_sent_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Index of the final beat: ceil(len/8)-1 == floor((len-1)/8) for len >= 1.
  function automatic logic [LEN_WIDTH-1:0] last_beat_idx(input logic [LEN_WIDTH-1:0] len);
    return (len - LEN_WIDTH'(1)) >> 3;
  endfunction

  function automatic logic [7:0] last_beat_keep(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : (8'hFF >> (4'd8 - {1'b0, rem}));
  endfunction

  logic err_in;
`ifdef IPG_PKT_GEN_ERR_INJ_EN
  assign err_in = err_inject;
`else
  assign err_in = 1'b0;
`endif

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [7:0]           keep_last_q, keep_last_d;
  logic [31:0]          count_q, count_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]          beat_idx_q, beat_idx_d;
  logic [31:0]          run_sent_q, run_sent_d;
  logic                 err_q, err_d;

  logic [63:0]          tdata_d;
  logic [7:0]           tkeep_d;
  logic                 tvalid_d, tlast_d, tuser_d;
  logic                 busy_d, done_d, cfg_err_d;
  logic [31:0]          pkt_sent_count_d;

  logic                 load, drop, beat_last;
  logic [31:0]          load_seq;
  logic [LEN_WIDTH-1:0] load_last_idx;
  logic [7:0]           load_keep;

  always_comb begin
    state_d          = state_q;
    last_idx_d       = last_idx_q;
    keep_last_d      = keep_last_q;
    count_d          = count_q;
    gap_d            = gap_q;
    gap_cnt_d        = gap_cnt_q;
    beat_idx_d       = beat_idx_q;
    run_sent_d       = run_sent_q;
    err_d            = err_q;
    tdata_d          = m_axis_tdata;
    tkeep_d          = m_axis_tkeep;
    tvalid_d         = m_axis_tvalid;
    tlast_d          = m_axis_tlast;
    tuser_d          = m_axis_tuser;
    done_d           = 1'b0;
    cfg_err_d        = 1'b0;
    pkt_sent_count_d = pkt_sent_count;
    load             = 1'b0;
    drop             = 1'b0;
    load_seq         = pkt_sent_count;
    load_last_idx    = last_idx_q;
    load_keep        = keep_last_q;
    beat_last        = (beat_idx_q == 32'(last_idx_q));

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_pkt_len == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            last_idx_d    = last_beat_idx(cfg_pkt_len);
            keep_last_d   = last_beat_keep(cfg_pkt_len[2:0]);
            count_d       = cfg_pkt_count;
            gap_d         = cfg_gap_cycles;
            run_sent_d    = '0;
            load_last_idx = last_idx_d;
            load_keep     = keep_last_d;
            load          = 1'b1;
            state_d       = SEND;
          end
        end
      end
      SEND: begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (beat_last) begin
            pkt_sent_count_d = pkt_sent_count + 32'd1;
            run_sent_d       = run_sent_q + 32'd1;
            if (((count_q != '0) && (run_sent_d == count_q)) || stop) begin
              state_d = IDLE;
              done_d  = 1'b1;
              drop    = 1'b1;
            end else if (gap_q == '0) begin
              load     = 1'b1;
              load_seq = pkt_sent_count_d;
            end else begin
              state_d   = GAP;
              gap_cnt_d = gap_q - GAP_WIDTH'(1);
              drop      = 1'b1;
            end
          end else begin
            beat_idx_d = beat_idx_q + 32'd1;
            tdata_d    = {m_axis_tdata[63:32], beat_idx_d};
            tlast_d    = (beat_idx_d == 32'(last_idx_q));
            tkeep_d    = tlast_d ? keep_last_q : 8'hFF;
            tuser_d    = err_q & tlast_d;
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == '0) begin
          load    = 1'b1;
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
      tkeep_d  = '0;
    end

    // First beat of a packet; err_inject is sampled only here.
    if (load) begin
      beat_idx_d = '0;
      tdata_d    = {load_seq, 32'd0};
      tvalid_d   = 1'b1;
      tlast_d    = (load_last_idx == '0);
      tkeep_d    = tlast_d ? load_keep : 8'hFF;
      err_d      = err_in;
      tuser_d    = err_in & tlast_d;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q        <= IDLE;
      last_idx_q     <= '0;
      keep_last_q    <= '0;
      count_q        <= '0;
      gap_q          <= '0;
      gap_cnt_q      <= '0;
      beat_idx_q     <= '0;
      run_sent_q     <= '0;
      err_q          <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
      pkt_sent_count <= '0;
    end else begin
      state_q        <= state_d;
      last_idx_q     <= last_idx_d;
      keep_last_q    <= keep_last_d;
      count_q        <= count_d;
      gap_q          <= gap_d;
      gap_cnt_q      <= gap_cnt_d;
      beat_idx_q     <= beat_idx_d;
      run_sent_q     <= run_sent_d;
      err_q          <= err_d;
      m_axis_tdata   <= tdata_d;
      m_axis_tkeep   <= tkeep_d;
      m_axis_tvalid  <= tvalid_d;
      m_axis_tlast   <= tlast_d;
      m_axis_tuser   <= tuser_d;
      busy           <= busy_d;
      done           <= done_d;
      cfg_err        <= cfg_err_d;
      pkt_sent_count <= pkt_sent_count_d;
    end
  end

endmodule

// File: tb/tb_ipg_axis_pkt_gen.sv
// Bench for ipg_axis_pkt_gen: directed runs with randomized tready/noise against a cycle-level packet model.
module tb_ipg_axis_pkt_gen;

`ifdef IPG_PKT_GEN_ERR_INJ_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam bit [0:5] RDY_PAT = 6'b100101;

  logic        tx_clk = 1'b0;
  logic        tx_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_pkt_len = '0;
  logic [31:0] cfg_pkt_count = '0;
  logic [7:0]  cfg_gap_cycles = '0;
  logic        err_drv = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic        busy, done, cfg_err;
  logic [31:0] pkt_sent_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned exp_cnt = 0;

  always #5 tx_clk = ~tx_clk;

  ipg_axis_pkt_gen #(.LEN_WIDTH(16), .GAP_WIDTH(8)) dut (
    .tx_clk         (tx_clk),
    .tx_rst_n       (tx_rst_n),
    .start          (start),
    .stop           (stop),
    .cfg_pkt_len    (cfg_pkt_len),
    .cfg_pkt_count  (cfg_pkt_count),
    .cfg_gap_cycles (cfg_gap_cycles),
`ifdef IPG_PKT_GEN_ERR_INJ_EN
    .err_inject     (err_drv),
`endif
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .pkt_sent_count (pkt_sent_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; reset lands mid-low-phase, away from any clock edge.
  task automatic apply_reset();
    #2 tx_rst_n = 1'b0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_count", pkt_sent_count, 0);
    start = 1'b0;
    stop = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge tx_clk);
    tx_rst_n = 1'b1;
    repeat (2) @(negedge tx_clk);
    chk("post_rst_tvalid", m_axis_tvalid, 0);
    chk("post_rst_busy", busy, 0);
    exp_cnt = 0;
  endtask

  // rdy_pct < 0 selects the fixed ready pattern; stop_beat < 0 asserts stop in the gap after stop_pkt packets.
  task automatic run_pkts(input int len, input int unsigned count, input int gap, input int rdy_pct,
                          input int stop_pkt, input int stop_beat, input int rst_beat);
    int beats, pkt, beat, phase, k, cyc;
    bit stop_lvl, cur_err, last;
    logic [7:0] last_keep;
    beats = (len + 7) / 8;
    last_keep = (len % 8 == 0) ? 8'hFF : 8'((1 << (len % 8)) - 1);
    pkt = 0; beat = 0; phase = 0; k = 0; cyc = 0; stop_lvl = 1'b0;
    cfg_pkt_len = 16'(len);
    cfg_pkt_count = count;
    cfg_gap_cycles = 8'(gap);
    stop = 1'b0;
    err_drv = 1'($urandom);
    cur_err = err_drv;
    start = 1'b1;
    @(negedge tx_clk);
    while (phase != 3) begin
      start = (phase < 2) && ($urandom_range(7) == 0);
      cfg_pkt_len = 16'($urandom);
      cfg_pkt_count = $urandom;
      cfg_gap_cycles = 8'($urandom);
      err_drv = 1'($urandom);
      m_axis_tready = (rdy_pct < 0) ? RDY_PAT[cyc % 6] : ($urandom_range(99) < rdy_pct);
      if (phase == 0 && pkt == stop_pkt && stop_beat >= 0 && beat == stop_beat) stop_lvl = 1'b1;
      if (phase == 1 && pkt == stop_pkt && stop_beat < 0) stop_lvl = 1'b1;
      stop = stop_lvl;
      if (rst_beat >= 0 && phase == 0 && pkt == 0 && beat == rst_beat) begin
        apply_reset();
        return;
      end
      chk("sent_count", pkt_sent_count, 64'(32'(exp_cnt + pkt)));
      case (phase)
        0: begin
          last = (beat == beats - 1);
          chk("tvalid", m_axis_tvalid, 1);
          chk("tdata", m_axis_tdata, {32'(exp_cnt + pkt), 32'(beat)});
          chk("tkeep", m_axis_tkeep, last ? last_keep : 8'hFF);
          chk("tlast", m_axis_tlast, last);
          chk("tuser", m_axis_tuser, ERR_EN && cur_err && last);
          chk("busy", busy, 1);
          chk("done_early", done, 0);
          if (m_axis_tready) begin
            if (!last) beat++;
            else begin
              pkt++;
              beat = 0;
              if ((count != 0 && unsigned'(pkt) == count) || stop_lvl) phase = 2;
              else if (gap == 0) cur_err = err_drv;
              else begin phase = 1; k = gap; end
            end
          end
        end
        1: begin
          chk("gap_tvalid", m_axis_tvalid, 0);
          chk("gap_busy", busy, 1);
          chk("gap_done", done, 0);
          if (stop_lvl) phase = 2;
          else begin
            k--;
            if (k == 0) begin phase = 0; cur_err = err_drv; end
          end
        end
        default: begin
          chk("done", done, 1);
          chk("busy_end", busy, 0);
          chk("end_tvalid", m_axis_tvalid, 0);
          chk("end_cfg_err", cfg_err, 0);
          exp_cnt += pkt;
          pkt = 0;
          phase = 3;
        end
      endcase
      cyc++;
      @(negedge tx_clk);
      if (phase != 3 && cyc > 4000) begin
        vectors++;
        miscompares++;
        $error("FAIL run_timeout observed=%0d cycles expected=done", cyc);
        apply_reset();
        return;
      end
    end
    start = 1'b0;
    stop = 1'b0;
    chk("done_pulse_width", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    @(negedge tx_clk);
    apply_reset();

    run_pkts(8, 1, 0, 100, -1, 0, -1);
    chk("count_after_single", pkt_sent_count, 1);
    run_pkts(64, 3, 12, 100, -1, 0, -1);
    chk("count_after_three", pkt_sent_count, 4);
    run_pkts(13, 1, 0, 100, -1, 0, -1);
    run_pkts(24, 2, 0, -1, -1, 0, -1);
    run_pkts(64, 0, 0, 100, 4, 2, -1);
    run_pkts(24, 0, 3, 70, 2, -1, -1);

    cfg_pkt_len = '0;
    cfg_pkt_count = 32'd1;
    start = 1'b1;
    @(negedge tx_clk);
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_tvalid", m_axis_tvalid, 0);
    @(negedge tx_clk);
    chk("cfg_err_width", cfg_err, 0);
    chk("cfg_err_idle", busy, 0);

    run_pkts(64, 1, 0, 100, -1, 0, 3);
    run_pkts(64, 1, 0, 100, -1, 0, -1);
    chk("count_after_reset_run", pkt_sent_count, 1);

    for (int i = 0; i < 8; i++)
      run_pkts(int'($urandom_range(1, 100)), $urandom_range(1, 4), int'($urandom_range(0, 5)),
               int'($urandom_range(30, 100)), -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
